// File: rtl/dmem_pkg.sv
// Shared types and helpers for the stalling data memory.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;

   typedef enum logic {OP_RD, OP_WR} dmem_op_t;

   // Counter width able to hold the latency value.
   function automatic int unsigned cnt_width(input int unsigned lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Storage for dmem_stall: NWORDS x NBITS, combinational read, synchronous write.
module dmem_array #(
   parameter int unsigned NBITS  = 8,
   parameter int unsigned NWORDS = 16,
   parameter int unsigned IW     = $clog2(NWORDS)
) (
   input  logic             clock,
   input  logic             i_we,
   input  logic [IW-1:0]    i_idx,
   input  logic [NBITS-1:0] i_wdata,
   output logic [NBITS-1:0] o_rdata
);

   logic [NBITS-1:0] r_mem [NWORDS];

   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_stall.sv
// Multi-cycle data memory that stalls the controller for LAT cycles per access.
// Define DMEM_LASTHIT_EN to add a one-entry last-access buffer for zero-wait read hits.
module dmem_stall
   import dmem_pkg::*;
#(
   parameter int unsigned NBITS  = 8,
   parameter int unsigned NWORDS = 16,
   parameter int unsigned LAT    = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic [NBITS-1:0] addr,
   input  logic [NBITS-1:0] wdata,
   output logic [NBITS-1:0] rdata,
   output logic             busy,
   output logic             valid
);

   localparam int unsigned CW = cnt_width(LAT);
   localparam int unsigned IW = $clog2(NWORDS);

   dmem_state_t      r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   dmem_op_t         r_op, w_op_nxt;
   logic             w_req;
   logic             w_we;
   logic [IW-1:0]    w_idx;
   logic [NBITS-1:0] w_arr_rdata;
   logic             w_unused_addr;

   assign w_req         = MemRead | MemWrite;
   assign w_idx         = addr[IW-1:0];
   assign w_unused_addr = ^addr[NBITS-1:IW];

`ifdef DMEM_LASTHIT_EN
   logic             r_hit_vld;
   logic [IW-1:0]    r_hit_idx;
   logic [NBITS-1:0] r_hit_data;
   logic             w_hit;

   assign w_hit = MemRead & ~MemWrite & r_hit_vld & (r_hit_idx == w_idx);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_hit_vld  <= 1'b0;
         r_hit_idx  <= '0;
         r_hit_data <= '0;
      end else if (r_state == DONE) begin
         r_hit_vld  <= 1'b1;
         r_hit_idx  <= w_idx;
         r_hit_data <= (r_op == OP_WR) ? wdata : w_arr_rdata;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_op    <= OP_RD;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
      end
   end

   // IDLE with a request is the first busy cycle, so WAIT lasts LAT-1 cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      busy        = 1'b0;
      valid       = 1'b0;
      rdata       = '0;
      w_we        = 1'b0;
      unique case (r_state)
         IDLE: begin
`ifdef DMEM_LASTHIT_EN
            if (w_hit) begin
               valid = 1'b1;
               rdata = r_hit_data;
            end else if (w_req) begin
`else
            if (w_req) begin
`endif
               busy        = 1'b1;
               w_op_nxt    = MemWrite ? OP_WR : OP_RD;
               w_cnt_nxt   = CW'(LAT - 1);
               w_state_nxt = (LAT == 1) ? DONE : WAIT;
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (!w_req) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == CW'(1)) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         DONE: begin
            valid       = 1'b1;
            w_state_nxt = IDLE;
            if (r_op == OP_RD) begin
               rdata = w_arr_rdata;
            end else begin
               w_we = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Reset wins over everything, including a write in DONE.
      if (reset) begin
         busy  = 1'b0;
         valid = 1'b0;
         rdata = '0;
         w_we  = 1'b0;
      end
   end

   dmem_array #(
      .NBITS  (NBITS),
      .NWORDS (NWORDS),
      .IW     (IW)
   ) u_array (
      .clock   (clock),
      .i_we    (w_we),
      .i_idx   (w_idx),
      .i_wdata (wdata),
      .o_rdata (w_arr_rdata)
   );

endmodule

// File: tb/tb_dmem_stall.sv
// Directed self-checking bench for dmem_stall (LAT=3, NWORDS=16, NBITS=8).
module tb_dmem_stall;

   localparam int unsigned NBITS  = 8;
   localparam int unsigned NWORDS = 16;
   localparam int unsigned LAT    = 3;

   logic             clock;
   logic             reset;
   logic             MemRead;
   logic             MemWrite;
   logic [NBITS-1:0] addr;
   logic [NBITS-1:0] wdata;
   logic [NBITS-1:0] rdata;
   logic             busy;
   logic             valid;

   int n_checks = 0;
   int n_err    = 0;

   // Model of the last-access buffer (only consulted when the feature is built in).
   logic       tb_vld = 1'b0;
   logic [3:0] tb_idx = '0;

   dmem_stall #(
      .NBITS  (NBITS),
      .NWORDS (NWORDS),
      .LAT    (LAT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .valid    (valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Full access; called and returns at 1 time unit after a rising edge.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
      logic hit;
      hit = 1'b0;
`ifdef DMEM_LASTHIT_EN
      hit = rd && !wr && tb_vld && (tb_idx == a[3:0]);
`endif
      MemRead  = rd;
      MemWrite = wr;
      addr     = a;
      wdata    = d;
      if (!hit) begin
         for (int i = 0; i < int'(LAT); i++) begin
            @(negedge clock);
            check({tag, "/busy"}, 32'(busy), 32'd1);
            check({tag, "/novalid"}, 32'(valid), 32'd0);
            next_cycle();
         end
      end
      @(negedge clock);
      check({tag, "/done_busy"}, 32'(busy), 32'd0);
      check({tag, "/valid"}, 32'(valid), 32'd1);
      check({tag, "/rdata"}, 32'(rdata), 32'(exp_rd));
      next_cycle();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      tb_vld   = 1'b1;
      tb_idx   = a[3:0];
   endtask

   initial begin
      reset    = 1'b1;
      MemRead  = 1'b1;
      MemWrite = 1'b0;
      addr     = '0;
      wdata    = '0;
      next_cycle();
      next_cycle();
      // Request held during reset must not stall.
      @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      next_cycle();
      reset   = 1'b0;
      MemRead = 1'b0;
      @(negedge clock);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(valid), 32'd0);
      next_cycle();

      // Basic write then read back.
      access("wr05", 1'b0, 1'b1, 8'h05, 8'hA5, 8'h00);
      access("rd05", 1'b1, 1'b0, 8'h05, 8'h00, 8'hA5);

      // Index wrap.
      access("wr13", 1'b0, 1'b1, 8'h13, 8'h3C, 8'h00);
      access("rd03", 1'b1, 1'b0, 8'h03, 8'h00, 8'h3C);

      // Read aborted after one cycle.
      MemRead = 1'b1;
      addr    = 8'h01;
      @(negedge clock);
      check("abrd_busy0", 32'(busy), 32'd1);
      next_cycle();
      MemRead = 1'b0;
      @(negedge clock);
      check("abrd_busy1", 32'(busy), 32'd1);
      check("abrd_valid1", 32'(valid), 32'd0);
      next_cycle();
      @(negedge clock);
      check("abrd_idle_busy", 32'(busy), 32'd0);
      check("abrd_idle_valid", 32'(valid), 32'd0);
      next_cycle();

      // Write aborted mid-WAIT must not commit.
      MemWrite = 1'b1;
      addr     = 8'h02;
      wdata    = 8'h77;
      @(negedge clock);
      check("abwr_busy0", 32'(busy), 32'd1);
      next_cycle();
      @(negedge clock);
      check("abwr_busy1", 32'(busy), 32'd1);
      next_cycle();
      MemWrite = 1'b0;
      @(negedge clock);
      check("abwr_busy2", 32'(busy), 32'd1);
      check("abwr_valid2", 32'(valid), 32'd0);
      next_cycle();
      @(negedge clock);
      check("abwr_idle_valid", 32'(valid), 32'd0);
      check("abwr_idle_busy", 32'(busy), 32'd0);
      next_cycle();
      access("rd02", 1'b1, 1'b0, 8'h02, 8'h00, 8'h00);

      // Reset during the DONE cycle of a write drops the write.
      MemWrite = 1'b1;
      addr     = 8'h04;
      wdata    = 8'hFF;
      for (int i = 0; i < int'(LAT); i++) begin
         next_cycle();
      end
      reset = 1'b1;
      @(negedge clock);
      check("rstdone_busy", 32'(busy), 32'd0);
      check("rstdone_valid", 32'(valid), 32'd0);
      next_cycle();
      reset    = 1'b0;
      MemWrite = 1'b0;
      tb_vld   = 1'b0;
      @(negedge clock);
      check("postrst_busy", 32'(busy), 32'd0);
      check("postrst_valid", 32'(valid), 32'd0);
      next_cycle();
      access("rd04", 1'b1, 1'b0, 8'h04, 8'h00, 8'h00);

      // Read and write together is a write.
      access("rw06", 1'b1, 1'b1, 8'h06, 8'h11, 8'h00);
      access("rd06", 1'b1, 1'b0, 8'h06, 8'h00, 8'h11);

      // Last-hit sequence; read of 07 hits only when the buffer is built in.
      access("wr07", 1'b0, 1'b1, 8'h07, 8'h5A, 8'h00);
      access("rd07", 1'b1, 1'b0, 8'h07, 8'h00, 8'h5A);
      access("rd08", 1'b1, 1'b0, 8'h08, 8'h00, 8'h00);
      access("rd05b", 1'b1, 1'b0, 8'h05, 8'h00, 8'hA5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
